// File: rtl/opamp_pkg.sv
// opamp_pkg: mode encoding and rail helpers shared by the op-amp slew model
package opamp_pkg;

    typedef enum logic {
        OPAMP_FOLLOW = 1'b0,
        OPAMP_DIFF   = 1'b1
    } opamp_mode_e;

    function automatic int out_max(input int width, input int headroom);
        return (1 << (width - 1)) - 1 - headroom;
    endfunction

    function automatic int out_min(input int width, input int headroom);
        return headroom - (1 << (width - 1));
    endfunction

endpackage

// File: rtl/opamp_slew_chan.sv
// opamp_slew_chan: one slew-limited amplifier channel (target, clamp, slew, settled, clip)
// OPAMP_CLIP_FLAG_EN builds the sticky clip flag; otherwise clip is tied low
module opamp_slew_chan
    import opamp_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int SLEW     = 16,
    parameter int GAIN     = 1,
    parameter int HEADROOM = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwr_ok,
    input  logic             mode,
    input  logic             clip_clr,
    input  logic [WIDTH-1:0] in_p,
    input  logic [WIDTH-1:0] in_n,
    output logic [WIDTH-1:0] out,
    output logic             settled,
    output logic             clip
);

    // wide enough for GAIN*(in_p-in_n) without overflow
    localparam int TW = WIDTH + $clog2(GAIN) + 2;
    localparam logic signed [TW-1:0] HI   = TW'(out_max(WIDTH, HEADROOM));
    localparam logic signed [TW-1:0] LO   = TW'(out_min(WIDTH, HEADROOM));
    localparam logic signed [TW-1:0] STEP = TW'(SLEW);
    localparam logic signed [TW-1:0] G    = TW'(GAIN);

    logic signed [TW-1:0] p, n, raw, tgt, cur, d;
    logic [WIDTH-1:0] nxt;
    logic hi, lo, near;

    always_comb begin
        p    = TW'($signed(in_p));
        n    = TW'($signed(in_n));
        raw  = (mode == OPAMP_DIFF) ? (p - n) * G : p;
        hi   = raw > HI;
        lo   = raw < LO;
        tgt  = hi ? HI : lo ? LO : raw;
        cur  = TW'($signed(out));
        d    = tgt - cur;
        near = (d <= STEP) && (d >= -STEP);
        nxt  = near ? tgt[WIDTH-1:0] : WIDTH'(d[TW-1] ? cur - STEP : cur + STEP);
    end

    // supply loss collapses the output at once rather than slewing it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out     <= '0;
            settled <= 1'b0;
        end else if (!pwr_ok) begin
            out     <= '0;
            settled <= 1'b0;
        end else begin
            out     <= nxt;
            settled <= near;
        end
    end

`ifdef OPAMP_CLIP_FLAG_EN
    // clamping at the edge outranks a clear request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clip <= 1'b0;
        else        clip <= hi || lo || (clip && !clip_clr);
    end
`else
    logic unused_clip_clr;
    assign unused_clip_clr = clip_clr;
    assign clip = 1'b0;
`endif

endmodule

// File: rtl/opamp_slew_array.sv
// opamp_slew_array: multi-channel slew-limited op-amp model with rail clipping
// OPAMP_CLIP_FLAG_EN enables the per-channel sticky clip flags
module opamp_slew_array
    import opamp_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 12,
    parameter int SLEW     = 16,
    parameter int GAIN     = 1,
    parameter int HEADROOM = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pwr_ok,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS*WIDTH-1:0] in_p,
    input  logic [CHANNELS*WIDTH-1:0] in_n,
    input  logic                      clip_clr,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic [CHANNELS-1:0]       settled,
    output logic [CHANNELS-1:0]       clip
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        opamp_slew_chan #(
            .WIDTH    (WIDTH),
            .SLEW     (SLEW),
            .GAIN     (GAIN),
            .HEADROOM (HEADROOM)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .pwr_ok   (pwr_ok),
            .mode     (mode[c]),
            .clip_clr (clip_clr),
            .in_p     (in_p[c*WIDTH +: WIDTH]),
            .in_n     (in_n[c*WIDTH +: WIDTH]),
            .out      (out[c*WIDTH +: WIDTH]),
            .settled  (settled[c]),
            .clip     (clip[c])
        );
    end

endmodule

// File: tb/tb_opamp_slew_array.sv
// tb_opamp_slew_array: directed bench with an integer behavioural model checked every cycle
module tb_opamp_slew_array;

    localparam int CHANNELS = 2;
    localparam int WIDTH    = 12;
    localparam int SLEW     = 16;
    localparam int GAIN     = 4;
    localparam int HEADROOM = 0;
    localparam int OMAX     = 2 ** (WIDTH - 1) - 1 - HEADROOM;
    localparam int OMIN     = -(2 ** (WIDTH - 1)) + HEADROOM;
`ifdef OPAMP_CLIP_FLAG_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      pwr_ok = 1'b1;
    logic [CHANNELS-1:0]       mode = '0;
    logic [CHANNELS*WIDTH-1:0] in_p = '0;
    logic [CHANNELS*WIDTH-1:0] in_n = '0;
    logic                      clip_clr = 1'b0;
    logic [CHANNELS*WIDTH-1:0] out;
    logic [CHANNELS-1:0]       settled;
    logic [CHANNELS-1:0]       clip;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    int m_out  [CHANNELS] = '{default: 0};
    int m_set  [CHANNELS] = '{default: 0};
    int m_clip [CHANNELS] = '{default: 0};

    opamp_slew_array #(
        .CHANNELS (CHANNELS),
        .WIDTH    (WIDTH),
        .SLEW     (SLEW),
        .GAIN     (GAIN),
        .HEADROOM (HEADROOM)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwr_ok   (pwr_ok),
        .mode     (mode),
        .in_p     (in_p),
        .in_n     (in_n),
        .clip_clr (clip_clr),
        .out      (out),
        .settled  (settled),
        .clip     (clip)
    );

    always #5 clk = ~clk;

    function automatic int raw_of(int c);
        logic signed [WIDTH-1:0] pv, nv;
        pv = in_p[c*WIDTH +: WIDTH];
        nv = in_n[c*WIDTH +: WIDTH];
        return mode[c] ? GAIN * (int'(pv) - int'(nv)) : int'(pv);
    endfunction

    function automatic int tgt_of(int c);
        int r;
        r = raw_of(c);
        return r > OMAX ? OMAX : (r < OMIN ? OMIN : r);
    endfunction

    function automatic int o(int c);
        logic signed [WIDTH-1:0] v;
        v = out[c*WIDTH +: WIDTH];
        return int'(v);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int t, d, r;
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                m_out[c]  <= 0;
                m_set[c]  <= 0;
                m_clip[c] <= 0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                t = tgt_of(c);
                r = raw_of(c);
                d = t - m_out[c];
                if (!pwr_ok) begin
                    m_out[c] <= 0;
                    m_set[c] <= 0;
                end else if (d >= -SLEW && d <= SLEW) begin
                    m_out[c] <= t;
                    m_set[c] <= 1;
                end else begin
                    m_out[c] <= m_out[c] + (d > 0 ? SLEW : -SLEW);
                    m_set[c] <= 0;
                end
                if (CLIP_EN) begin
                    if (r != t) m_clip[c] <= 1;
                    else if (clip_clr) m_clip[c] <= 0;
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < CHANNELS; c++) begin
                chk($sformatf("model out ch%0d", c), o(c), m_out[c]);
                chk($sformatf("model settled ch%0d", c), int'(settled[c]), m_set[c]);
                chk($sformatf("model clip ch%0d", c), int'(clip[c]), m_clip[c]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_p(input int c, input int v);
        in_p[c*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    task automatic set_n(input int c, input int v);
        in_n[c*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    initial begin
        set_p(1, 5);
        repeat (2) step();
        chk("reset out0", o(0), 0);
        chk("reset settled0", int'(settled[0]), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        step();
        chk("idle settled0", int'(settled[0]), 1);
        chk("hold out1", o(1), 5);
        chk("hold settled1", int'(settled[1]), 1);

        set_p(0, 100);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("ramp up out0", o(0), (16 * k < 100) ? 16 * k : 100);
            chk("ramp up settled0", int'(settled[0]), int'(k == 7));
            chk("indep out1", o(1), 5);
            chk("indep settled1", int'(settled[1]), 1);
        end

        set_p(0, 0);
        repeat (7) step();
        chk("ramp down out0", o(0), 0);

        set_p(0, -40);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("neg out0", o(0), (-16 * k > -40) ? -16 * k : -40);
            chk("neg settled0", int'(settled[0]), int'(k == 3));
        end
        set_p(0, 0);
        repeat (3) step();
        chk("neg return out0", o(0), 0);
        set_p(0, 10);
        step();
        chk("small step out0", o(0), 10);
        chk("small step settled0", int'(settled[0]), 1);
        set_p(0, 0);
        step();

        mode[0] = 1'b1;
        set_p(0, 1000);
        step();
        chk("rail first out0", o(0), 16);
        chk("rail first clip0", int'(clip[0]), int'(CLIP_EN));
        repeat (126) step();
        chk("rail 127 out0", o(0), 2032);
        chk("rail 127 settled0", int'(settled[0]), 0);
        step();
        chk("rail 128 out0", o(0), 2047);
        chk("rail 128 settled0", int'(settled[0]), 1);
        clip_clr = 1'b1;
        step();
        chk("clr while clamped clip0", int'(clip[0]), int'(CLIP_EN));
        clip_clr = 1'b0;
        set_p(0, 0);
        step();
        chk("sticky clip0", int'(clip[0]), int'(CLIP_EN));
        chk("unclamp out0", o(0), 2031);
        clip_clr = 1'b1;
        step();
        chk("clr clip0", int'(clip[0]), 0);
        clip_clr = 1'b0;
        repeat (127) step();
        chk("rail return out0", o(0), 0);

        set_n(0, 600);
        repeat (2) step();
        chk("neg rail out0", o(0), -32);
        chk("neg rail clip0", int'(clip[0]), int'(CLIP_EN));
        set_n(0, 0);
        clip_clr = 1'b1;
        step();
        chk("neg rail clr out0", o(0), -16);
        chk("neg rail clr clip0", int'(clip[0]), 0);
        clip_clr = 1'b0;
        step();
        mode[0] = 1'b0;

        set_p(0, 100);
        repeat (3) step();
        chk("pre collapse out0", o(0), 48);
        pwr_ok = 1'b0;
        step();
        chk("collapse out0", o(0), 0);
        chk("collapse settled0", int'(settled[0]), 0);
        chk("collapse out1", o(1), 0);
        pwr_ok = 1'b1;
        step();
        chk("restore out0", o(0), 16);
        chk("restore out1", o(1), 5);
        step();
        chk("restore2 out0", o(0), 32);

        mode[1] = 1'b1;
        set_p(1, 1000);
        step();
        chk("ch1 clip", int'(clip[1]), int'(CLIP_EN));
        rst_n = 1'b0;
        #1;
        chk("async rst out0", o(0), 0);
        chk("async rst out1", o(1), 0);
        chk("async rst settled", int'(settled), 0);
        chk("async rst clip", int'(clip), 0);
        mode[1] = 1'b0;
        set_p(1, 5);
        step();
        chk("rst held out0", o(0), 0);
        rst_n = 1'b1;
        step();
        chk("post rst out0", o(0), 16);
        chk("post rst out1", o(1), 5);
        chk("post rst settled1", int'(settled[1]), 1);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
